// File: rtl/prco_pkg.sv
// Shared encodings for the prco execution controller: FSM states and
// run-mode DIP switch settings.
package prco_pkg;

  typedef enum logic [1:0] {
    PRCO_ST_IDLE = 2'd0,
    PRCO_ST_STEP = 2'd1,
    PRCO_ST_RUN  = 2'd2,
    PRCO_ST_BRK  = 2'd3
  } prco_state_e;

  typedef enum logic [1:0] {
    PRCO_MODE_HALT = 2'b00,
    PRCO_MODE_STEP = 2'b01,
    PRCO_MODE_RUN  = 2'b10,
    PRCO_MODE_SLOW = 2'b11
  } prco_mode_e;

  // States in which the core is allowed to execute.
  function automatic logic prco_core_active(input prco_state_e st);
    return (st == PRCO_ST_STEP) || (st == PRCO_ST_RUN);
  endfunction

endpackage

// File: rtl/prco_step_ctrl_if.sv
// Board/core-side signal bundle of prco_step_ctrl. The master modport is the
// controller's view; the slave modport is the board/core environment.
interface prco_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_btn;
  logic [1:0]       i_mode;
  logic             i_instr_done;
  logic             i_bp_hit;
  logic             q_core_en;
  logic [1:0]       q_state;
  logic             q_fault;
  logic             q_btn_evt;
  logic [CNT_W-1:0] q_step_cnt;

  modport master (
    input  i_btn, i_mode, i_instr_done, i_bp_hit,
    output q_core_en, q_state, q_fault, q_btn_evt, q_step_cnt
  );

  modport slave (
    output i_btn, i_mode, i_instr_done, i_bp_hit,
    input  q_core_en, q_state, q_fault, q_btn_evt, q_step_cnt
  );
endinterface

// File: rtl/prco_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, optional periodic sampler and
// rising-edge detector. Sampler present only with PRCO_STEP_CTRL_DEBOUNCE_EN.
module prco_btn_debounce #(
  parameter int LGWAIT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic q_evt
);

  logic sync1_q;
  logic sync2_q;
  logic lvl;
  logic lvl_prev_q;
  logic evt_q;

  if (LGWAIT < 1) begin : g_lgwait_chk
    $error("prco_btn_debounce: LGWAIT must be at least 1");
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef PRCO_STEP_CTRL_DEBOUNCE_EN
  logic [LGWAIT-1:0] tmr_q;
  logic              smp_q;

  // Sampling only once per timer period hides contact bounce shorter
  // than 2^LGWAIT clocks.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmr_q <= '1;
      smp_q <= 1'b0;
    end else begin
      tmr_q <= tmr_q - 1'b1;
      if (tmr_q == '0) begin
        smp_q <= sync2_q;
      end
    end
  end

  assign lvl = smp_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lvl_prev_q <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      evt_q      <= lvl & ~lvl_prev_q;
    end
  end

  assign q_evt = evt_q;

endmodule

// File: rtl/prco_step_ctrl.sv
// Execution controller for prco_core: halt / single-step / run / slow-run,
// retired-instruction counter, breakpoint stop and stall watchdog.
// Build option: PRCO_STEP_CTRL_DEBOUNCE_EN enables the button debounce sampler.
module prco_step_ctrl
  import prco_pkg::*;
#(
  parameter int LGWAIT = 16,
  parameter int SLOW_W = 24,
  parameter int WDT_W  = 12,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  prco_step_ctrl_if.master ctl
);

  prco_state_e       state_q;
  prco_state_e       state_d;
  logic              core_en_q;
  logic              core_en_d;
  logic              fault_q;
  logic              fault_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WDT_W-1:0]  wdt_q;
  logic [WDT_W-1:0]  wdt_d;
  logic [SLOW_W-1:0] slow_q;
  logic [SLOW_W-1:0] slow_d;

  logic       btn_evt;
  prco_mode_e mode;
  logic       active;
  logic       wdt_term;
  logic       slow_tick;

  prco_btn_debounce #(
    .LGWAIT (LGWAIT)
  ) u_btn (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn     (ctl.i_btn),
    .q_evt     (btn_evt)
  );

  assign mode      = prco_mode_e'(ctl.i_mode);
  assign active    = prco_core_active(state_q);
  assign wdt_term  = &wdt_q;
  assign slow_tick = (slow_q == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= PRCO_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A retiring instruction outranks the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRCO_ST_IDLE: begin
        case (mode)
          PRCO_MODE_STEP: if (btn_evt)   state_d = PRCO_ST_STEP;
          PRCO_MODE_RUN:                 state_d = PRCO_ST_RUN;
          PRCO_MODE_SLOW: if (slow_tick) state_d = PRCO_ST_STEP;
          default:                       state_d = PRCO_ST_IDLE;
        endcase
      end
      PRCO_ST_STEP: begin
        if (ctl.i_instr_done) begin
          state_d = ctl.i_bp_hit ? PRCO_ST_BRK : PRCO_ST_IDLE;
        end else if (wdt_term) begin
          state_d = PRCO_ST_BRK;
        end
      end
      PRCO_ST_RUN: begin
        if (ctl.i_instr_done) begin
          if (ctl.i_bp_hit) begin
            state_d = PRCO_ST_BRK;
          end else if (mode != PRCO_MODE_RUN) begin
            state_d = PRCO_ST_IDLE;
          end
        end else if (wdt_term) begin
          state_d = PRCO_ST_BRK;
        end
      end
      default: begin
        if (btn_evt || (mode == PRCO_MODE_HALT)) begin
          state_d = PRCO_ST_IDLE;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so the enable moves on the
  // same edge as the state.
  always_comb begin
    core_en_d = prco_core_active(state_d);
    fault_d   = fault_q;
    if ((state_q == PRCO_ST_BRK) && (state_d == PRCO_ST_IDLE)) begin
      fault_d = 1'b0;
    end else if (active && !ctl.i_instr_done && wdt_term) begin
      fault_d = 1'b1;
    end
    cnt_d  = (active && ctl.i_instr_done) ? cnt_q + 1'b1 : cnt_q;
    wdt_d  = (active && !ctl.i_instr_done) ? wdt_q + 1'b1 : '0;
    slow_d = slow_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      core_en_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      wdt_q     <= '0;
      slow_q    <= '1;
    end else begin
      core_en_q <= core_en_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      wdt_q     <= wdt_d;
      slow_q    <= slow_d;
    end
  end

  assign ctl.q_core_en  = core_en_q;
  assign ctl.q_state    = state_q;
  assign ctl.q_fault    = fault_q;
  assign ctl.q_btn_evt  = btn_evt;
  assign ctl.q_step_cnt = cnt_q;

endmodule
